mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: BUSY cycles without mem_ready before abort (range 2..255).
REQ-002 Port clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  in  1  reset, synchronous, active-low.
REQ-004 Ports if_req in 1, if_addr in 32: instruction-fetch request and word address.
REQ-005 Ports if_gnt out 1, if_valid out 1, if_rdata out 32: fetch grant pulse, completion pulse, fetched instruction word.
REQ-006 Ports ls_req in 1, ls_we in 1, ls_addr in 32, ls_wdata in 32: slot-2 load/store request; ls_we=1 store, 0 load.
REQ-007 Ports ls_gnt out 1, ls_valid out 1, ls_rdata out 32: load/store grant pulse, completion pulse, load data.
REQ-008 Ports mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32, mem_ready in 1: single-port memory.
REQ-009 Port busy  out 1  high whenever FSM is not IDLE; drives pipeline stall.
REQ-010 Port err  out 1  one-cycle pulse on memory timeout abort.

Function
REQ-011 FSM states SHALL be IDLE, BUSY_IF, BUSY_LS.
REQ-012 In IDLE, requests sampled at clock edge; winner latched (addr, we, wdata), FSM enters matching BUSY state next cycle.
REQ-013 Arbitration: ls_req wins over if_req, except when starve_cnt==3, then if_req wins.
REQ-014 starve_cnt (2-bit): +1 when ls wins while if_req high; cleared when fetch granted or if_req low in IDLE; saturates at 3.
REQ-015 Grant pulse (if_gnt/ls_gnt) SHALL be high exactly in first BUSY cycle; requester holds req and operands until gnt.
REQ-016 mem_en high for every BUSY cycle; mem_addr/mem_we/mem_wdata driven from latched values, stable until mem_ready; mem_en low in IDLE.
REQ-017 mem_we=0 in BUSY_IF always; mem_we=latched ls_we in BUSY_LS.
REQ-018 Cycle with mem_en & mem_ready completes transfer: FSM returns IDLE next cycle.
REQ-019 Completion: if_valid/ls_valid pulse one cycle after mem_ready; if_rdata/ls_rdata register mem_rdata at that edge and hold until next completion of same port.
REQ-020 ls_valid pulses for stores too; ls_rdata unchanged on stores.
REQ-021 Latency: req sampled edge k -> gnt, mem_en in cycle k+1; mem_ready in cycle m -> valid in cycle m+1; next grant earliest m+2.
REQ-022 Requests arriving while BUSY are ignored until IDLE; no queueing.
REQ-023 Simultaneous if_req and ls_req with starve_cnt<3: ls granted, if_req left pending.

Reset
REQ-024 rst_n low at edge: FSM IDLE, starve_cnt 0, timeout counter 0, all gnt/valid/err/mem_en/mem_we/busy 0, mem_addr/mem_wdata/if_rdata/ls_rdata 32'h0.
REQ-025 Reset mid-transfer SHALL abort without valid pulse; mem_en low the following cycle.

Configuration
REQ-026 Macro MEM_ARB_TIMEOUT_EN defined: 8-bit counter counts BUSY cycles with mem_ready low; on reaching TIMEOUT_CYC, FSM to IDLE, mem_en drops, err and owning valid pulse one cycle, rdata register loaded with 32'hDEADBEEF (stores: rdata unchanged).
REQ-027 Macro undefined: no counter, err tied 0, BUSY waits indefinitely for mem_ready.

Verification
REQ-028 ls_req load addr 32'h100, mem_ready 2 cycles after mem_en, mem_rdata 32'hA5A5_0001 -> ls_gnt cycle 1, ls_valid with ls_rdata 32'hA5A5_0001 cycle 4, mem_we 0.
REQ-029 if_req and ls_req both high 5 transactions, mem_ready immediate -> grant order LS,LS,LS,IF,LS.
REQ-030 ls_req store addr 32'h20 wdata 32'h1234 -> mem_we 1, mem_wdata 32'h1234 throughout BUSY, ls_valid pulse, ls_rdata unchanged.
REQ-031 rst_n low in 2nd BUSY_IF cycle -> next cycle mem_en 0, busy 0, no if_valid.
REQ-032 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=4, mem_ready held 0 on load -> err and ls_valid pulse after 4 BUSY cycles, ls_rdata 32'hDEADBEEF; undefined -> busy stays 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates one single-port memory between an instruction-fetch port and
//   a load/store port. Load/store normally wins. A 2-bit starvation counter
//   hands the memory to a waiting fetch after three load/store wins in a row.
//   Each transfer is a grant cycle followed by BUSY cycles until mem_ready.
//   Completion is reported one cycle after mem_ready.
//
// Parameter
//   TIMEOUT_CYC  BUSY cycles without mem_ready before an abort (2..255).
//                It is only used when MEM_ARB_TIMEOUT_EN is defined.
//
// Build option
//   MEM_ARB_TIMEOUT_EN  When defined, a stalled transfer is aborted. The abort
//                       pulses err and the owning valid. Load data becomes
//                       32'hDEADBEEF. When undefined, err is tied low and BUSY
//                       waits for mem_ready indefinitely.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   if_req, if_addr                fetch request and word address
//   if_gnt, if_valid, if_rdata     fetch grant pulse, completion pulse, data
//   ls_req, ls_we, ls_addr,
//   ls_wdata                       load/store request (ls_we=1 is a store)
//   ls_gnt, ls_valid, ls_rdata     load/store grant pulse, completion, data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata,
//   mem_ready                      single-port memory interface
//   busy                           high whenever a transfer is in progress
//   err                            one-cycle pulse on a timeout abort
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_LS = 2'd2;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    logic [1:0]  state_q,    state_d;
    logic [1:0]  starve_q,   starve_d;
    logic [31:0] addr_q,     addr_d;
    logic        we_q,       we_d;
    logic [31:0] wdata_q,    wdata_d;
    logic        if_gnt_q,   if_gnt_d;
    logic        ls_gnt_q,   ls_gnt_d;
    logic        if_valid_q, if_valid_d;
    logic        ls_valid_q, ls_valid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;

    logic in_busy;
    logic abort;
    logic ls_wins;

    assign in_busy = (state_q != S_IDLE);

    // Load/store has priority unless a pending fetch has already lost three times.
    assign ls_wins = ls_req && !(if_req && (starve_q == 2'd3));

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] tmo_q, tmo_d;
    logic       err_q, err_d;

    // tmo_q counts the BUSY cycles already spent without mem_ready. The abort
    // fires in the cycle that would be the TIMEOUT_CYC-th cycle without it.
    assign abort = in_busy && !mem_ready && (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = 8'd0;
        err_d = abort;
        if (in_busy && !mem_ready && !abort) begin
            tmo_d = tmo_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    // Keeps the parameter referenced when the timeout logic is not built.
    logic unused_cfg;
    assign unused_cfg = ^8'(TIMEOUT_CYC);
    assign abort      = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_gnt_d   = 1'b0;
        ls_gnt_d   = 1'b0;
        if_valid_d = 1'b0;
        ls_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (ls_wins) begin
                    state_d  = S_BUSY_LS;
                    ls_gnt_d = 1'b1;
                    addr_d   = ls_addr;
                    we_d     = ls_we;
                    wdata_d  = ls_wdata;
                end else if (if_req) begin
                    state_d  = S_BUSY_IF;
                    if_gnt_d = 1'b1;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                end

                // The count only grows while a fetch is actually left waiting.
                if (!if_req || !ls_wins) begin
                    starve_d = 2'd0;
                end else if (starve_q != 2'd3) begin
                    starve_d = starve_q + 2'd1;
                end
            end

            S_BUSY_IF, S_BUSY_LS: begin
                if (mem_ready || abort) begin
                    state_d = S_IDLE;
                    if (state_q == S_BUSY_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = abort ? ABORT_DATA : mem_rdata;
                    end else begin
                        ls_valid_d = 1'b1;
                        // Stores complete without touching the load data register.
                        if (!we_q) begin
                            ls_rdata_d = abort ? ABORT_DATA : mem_rdata;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            starve_q   <= 2'd0;
            addr_q     <= 32'h0;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            if_gnt_q   <= 1'b0;
            ls_gnt_q   <= 1'b0;
            if_valid_q <= 1'b0;
            ls_valid_q <= 1'b0;
            if_rdata_q <= 32'h0;
            ls_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_gnt_q   <= if_gnt_d;
            ls_gnt_q   <= ls_gnt_d;
            if_valid_q <= if_valid_d;
            ls_valid_q <= ls_valid_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign busy      = in_busy;
    assign mem_en    = in_busy;
    assign mem_we    = (state_q == S_BUSY_LS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_valid  = if_valid_q;
    assign ls_valid  = ls_valid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we, mem_ready;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic        if_gnt, if_valid, ls_gnt, ls_valid;
    logic [31:0] if_rdata, ls_rdata;
    logic        mem_en, mem_we, busy, err;
    logic [31:0] mem_addr, mem_wdata;

    int          tests = 0;
    int          fails = 0;
    int          sc;
    logic [31:0] exp_if_rd, exp_ls_rd;
    logic [1:0]  last_gnt;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_valid(ls_valid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .err(err)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end of run, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Reference arbitration: who wins this IDLE edge, and the starvation count after it.
    task automatic arb_model(output int w);
        if (ls_req && !(if_req && sc == 3)) w = 2;
        else if (if_req)                     w = 1;
        else                                 w = 0;
        if (!if_req || w == 1) sc = 0;
        else if (sc < 3)       sc = sc + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_gnt", if_gnt | ls_gnt, 1'b0);
        chk1("rst_valid", if_valid | ls_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        rst_n = 1'b1;
        sc = 0; exp_if_rd = 32'h0; exp_ls_rd = 32'h0;
    endtask

    // Called at a negedge in IDLE with requests already driven. Runs one full
    // arbitration; the memory answers after lat stall cycles with rdat.
    task automatic round(input int lat, input logic [31:0] rdat, output int w);
        logic [31:0] eaddr, ewd;
        logic        ewe;
        arb_model(w);
        eaddr = (w == 2) ? ls_addr : if_addr;
        ewe   = (w == 2) ? ls_we : 1'b0;
        ewd   = ls_wdata;
        @(negedge clk);
        last_gnt = {if_gnt, ls_gnt};
        if (w == 0) begin
            chk1("idle_busy", busy, 1'b0);
            chk1("idle_gnt", if_gnt | ls_gnt, 1'b0);
            return;
        end
        chk1("gnt_if", if_gnt, w == 1);
        chk1("gnt_ls", ls_gnt, w == 2);
        chk1("gnt_busy", busy, 1'b1);
        chk1("gnt_mem_en", mem_en, 1'b1);
        chk("gnt_mem_addr", mem_addr, eaddr);
        chk1("gnt_mem_we", mem_we, ewe);
        if (ewe) chk("gnt_mem_wdata", mem_wdata, ewd);
        if (w == 1) if_req = 1'b0; else ls_req = 1'b0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk1("wait_mem_en", mem_en, 1'b1);
            chk1("wait_gnt", if_gnt | ls_gnt, 1'b0);
            chk1("wait_valid", if_valid | ls_valid, 1'b0);
            chk("wait_mem_addr", mem_addr, eaddr);
            chk1("wait_mem_we", mem_we, ewe);
            if (ewe) chk("wait_mem_wdata", mem_wdata, ewd);
        end
        mem_ready = 1'b1; mem_rdata = rdat;
        @(negedge clk);
        mem_ready = 1'b0; mem_rdata = $urandom;
        if (w == 1) exp_if_rd = rdat;
        else if (!ewe) exp_ls_rd = rdat;
        chk1("done_if_valid", if_valid, w == 1);
        chk1("done_ls_valid", ls_valid, w == 2);
        chk("done_if_rdata", if_rdata, exp_if_rd);
        chk("done_ls_rdata", ls_rdata, exp_ls_rd);
        chk1("done_busy", busy, 1'b0);
        chk1("done_mem_en", mem_en, 1'b0);
        chk1("done_err", err, 1'b0);
    endtask

    initial begin
        int          w;
        logic [1:0]  order [5];
        logic [31:0] prev;
        order[0] = 2'b01; order[1] = 2'b01; order[2] = 2'b01;
        order[3] = 2'b10; order[4] = 2'b01;
        if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_we = 1'b0;
        mem_rdata = 32'h0;
        do_reset();

        // Load at 0x100, memory answers two cycles after mem_en rises.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
        round(2, 32'hA5A5_0001, w);
        chk("load_ls_rdata", ls_rdata, 32'hA5A5_0001);

        // Both ports requesting continuously: LS,LS,LS,IF,LS.
        do_reset();
        for (int t = 0; t < 5; t++) begin
            if_req = 1'b1; if_addr = 32'h40 + 32'(t);
            ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80 + 32'(t);
            round(0, $urandom, w);
            chk("grant_order", {30'h0, last_gnt}, {30'h0, order[t]});
        end
        ls_req = 1'b0;
        round(1, $urandom, w);

        // Store leaves load data untouched.
        prev = ls_rdata;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h1234;
        round(2, 32'hFFFF_0000, w);
        chk("store_ls_rdata", ls_rdata, prev);

        // Reset during the second BUSY_IF cycle aborts silently.
        if_req = 1'b1; if_addr = 32'h300;
        arb_model(w);
        @(negedge clk);
        chk1("rstmid_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        @(negedge clk);
        chk1("rstmid_en_before", mem_en, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("rstmid_mem_en", mem_en, 1'b0);
        chk1("rstmid_busy", busy, 1'b0);
        chk1("rstmid_if_valid", if_valid, 1'b0);
        rst_n = 1'b1; sc = 0; exp_if_rd = 32'h0; exp_ls_rd = 32'h0;
        @(negedge clk);
        chk1("rstmid_if_valid2", if_valid, 1'b0);
        chk("rstmid_if_rdata", if_rdata, 32'h0);

        // Load that the memory never answers.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
        arb_model(w);
        @(negedge clk);
        chk1("tmo_gnt", ls_gnt, 1'b1);
        ls_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("tmo_wait_err", err, 1'b0);
            chk1("tmo_wait_busy", busy, 1'b1);
        end
        @(negedge clk);
        chk1("tmo_err", err, 1'b1);
        chk1("tmo_ls_valid", ls_valid, 1'b1);
        chk("tmo_ls_rdata", ls_rdata, 32'hDEAD_BEEF);
        chk1("tmo_busy", busy, 1'b0);
        chk1("tmo_mem_en", mem_en, 1'b0);
        exp_ls_rd = 32'hDEAD_BEEF;
        @(negedge clk);
        chk1("tmo_err_pulse", err, 1'b0);
        chk1("tmo_valid_pulse", ls_valid, 1'b0);
`else
        repeat (10) @(negedge clk);
        chk1("stall_busy", busy, 1'b1);
        chk1("stall_mem_en", mem_en, 1'b1);
        chk1("stall_err", err, 1'b0);
        chk1("stall_valid", ls_valid, 1'b0);
        do_reset();
`endif

        // Random traffic against the reference model.
        for (int r = 0; r < 60; r++) begin
            if (!if_req && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = $urandom;
            end
            if (!ls_req && $urandom_range(0, 1) == 1) begin
                ls_req = 1'b1; ls_we = 1'($urandom_range(0, 1));
                ls_addr = $urandom; ls_wdata = $urandom;
            end
            round($urandom_range(0, 3), $urandom, w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
